// File: rtl/cam_pkg.sv
// Shared constants and types for the camera downsample path.
// Optional build feature: PIXEL_COUNT_EN adds a per-frame write counter
// to downsample_writer.
package cam_pkg;

    // Default frame geometry and the derived half-resolution output
    localparam int H_IN_DEF = 320;
    localparam int V_IN_DEF = 240;
    localparam int H_OUT    = H_IN_DEF / 2;
    localparam int V_OUT    = V_IN_DEF / 2;

    // Frame-buffer address width (covers H_OUT*V_OUT = 19200 entries)
    localparam int ADDR_W   = 15;

    // Field widths on the pixel stream
    localparam int PIX_W    = 7;
    localparam int HCNT_W   = 11;
    localparam int VCNT_W   = 10;
    localparam int SUM_W    = PIX_W + 1;

    // Saturation ceiling for the optional write counter
    localparam logic [ADDR_W-1:0] CNT_SAT = '1;

    // One qualified sample on the incoming stream
    typedef struct packed {
        logic [PIX_W-1:0]  pix;
        logic [HCNT_W-1:0] hcount;
        logic [VCNT_W-1:0] vcount;
    } pix_req_t;

    // Average of two horizontal pair sums: 9-bit add, drop the low 2 bits
    function automatic logic [PIX_W-1:0] box_avg(input logic [SUM_W-1:0] top,
                                                 input logic [SUM_W-1:0] bot);
        logic [SUM_W:0] s;
        s = {1'b0, top} + {1'b0, bot};
        return s[SUM_W:2];
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Single-port line buffer holding the even-row pair sums of one output row.
// Registered read data: a read issued in cycle t is visible in cycle t+1 and
// is held until the next read.
module line_buffer
    import cam_pkg::*;
#(
    parameter int DEPTH = H_OUT,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int DW    = SUM_W
) (
    input  logic          system_clk_in,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:DEPTH-1];

    // Write-or-read single port; contents need no reset since every even
    // row rewrites the entries the following odd row reads
    always_ff @(posedge system_clk_in) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/downsample_writer.sv
// 2x2 box-filter downsampler writing a half-resolution frame buffer.
// Even rows leave horizontal pair sums in a line buffer; odd rows combine
// them with their own pair sums and emit one frame-buffer write per 2x2 block.
// Optional build feature: define PIXEL_COUNT_EN to add frame_pixel_count_out.
module downsample_writer
    import cam_pkg::*;
#(
    parameter int H_IN = H_IN_DEF,
    parameter int V_IN = V_IN_DEF
) (
    input  logic              system_clk_in,
    input  logic              rst_in,
    input  logic              data_valid_in,
    input  logic [PIX_W-1:0]  pixel_in,
    input  logic [HCNT_W-1:0] hcount_in,
    input  logic [VCNT_W-1:0] vcount_in,
    input  logic              frame_done_in,
    output logic              bram_we_out,
    output logic [ADDR_W-1:0] bram_addr_out,
    output logic [PIX_W-1:0]  bram_data_out,
    output logic              frame_complete_out
`ifdef PIXEL_COUNT_EN
    ,
    output logic [ADDR_W-1:0] frame_pixel_count_out
`endif
);

    localparam int H_HALF = H_IN / 2;
    localparam int LB_AW  = (H_HALF > 1) ? $clog2(H_HALF) : 1;
    localparam int STAGES = 1;

    localparam logic [HCNT_W-1:0] H_LIM  = HCNT_W'(H_IN);
    localparam logic [HCNT_W-1:0] H_LAST = HCNT_W'(H_IN - 1);
    localparam logic [VCNT_W-1:0] V_LIM  = VCNT_W'(V_IN);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_HALF);

    pix_req_t          req;
    logic              accept;
    logic              col_odd;
    logic              row_odd;
    logic              pair_ok;
    logic              last_pair;
    logic [LB_AW-1:0]  lb_idx;
    logic              lb_we;
    logic              lb_re;
    logic [SUM_W-1:0]  lb_rdata;
    logic [SUM_W-1:0]  pair_sum;
    logic [PIX_W-1:0]  hold_pix;
    logic              hold_valid;
    logic [ADDR_W-1:0] row_base;
    logic [STAGES:0]   vld_pipe;

    assign req = '{pix: pixel_in, hcount: hcount_in, vcount: vcount_in};

    // Out-of-frame samples are ignored; frame_done_in pre-empts a coincident sample
    assign accept  = data_valid_in && !frame_done_in &&
                     (req.hcount < H_LIM) && (req.vcount < V_LIM);
    assign col_odd = req.hcount[0];
    assign row_odd = req.vcount[0];
    assign lb_idx  = req.hcount[LB_AW:1];

    // An odd column only completes a pair if its even partner was captured
    assign pair_ok  = accept && col_odd && hold_valid;
    assign pair_sum = SUM_W'(hold_pix) + SUM_W'(req.pix);

    // Even rows store pair sums; odd rows pre-fetch on the even column so the
    // read data is ready by the odd column (strobes are >= 2 cycles apart)
    assign lb_we = pair_ok && !row_odd;
    assign lb_re = accept && !col_odd && row_odd;

    // Row base steps on the final column of an odd row, completed pair or not
    assign last_pair = accept && col_odd && row_odd && (req.hcount == H_LAST);

    assign vld_pipe[0] = pair_ok && row_odd;
    assign bram_we_out = vld_pipe[STAGES];

    line_buffer #(
        .DEPTH (H_HALF),
        .AW    (LB_AW),
        .DW    (SUM_W)
    ) u_line_buffer (
        .system_clk_in (system_clk_in),
        .en            (lb_we || lb_re),
        .we            (lb_we),
        .addr          (lb_idx),
        .wdata         (pair_sum),
        .rdata         (lb_rdata)
    );

    // Even-column capture; any accepted odd column consumes the held pixel
    always_ff @(posedge system_clk_in) begin
        if (rst_in || frame_done_in) begin
            hold_valid <= 1'b0;
            hold_pix   <= '0;
        end else if (accept) begin
            if (!col_odd) begin
                hold_pix   <= req.pix;
                hold_valid <= 1'b1;
            end else begin
                hold_valid <= 1'b0;
            end
        end
    end

    // Output-row base address, advanced by addition instead of a multiply
    always_ff @(posedge system_clk_in) begin
        if (rst_in || frame_done_in) row_base <= '0;
        else if (last_pair)          row_base <= row_base + ROW_STEP;
    end

    // Write strobe pipeline and held frame-buffer address/data
    always_ff @(posedge system_clk_in) begin
        if (rst_in) begin
            vld_pipe[STAGES:1] <= '0;
            bram_addr_out      <= '0;
            bram_data_out      <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            if (vld_pipe[0]) begin
                bram_addr_out <= row_base + ADDR_W'(lb_idx);
                bram_data_out <= box_avg(lb_rdata, pair_sum);
            end
        end
    end

    // One-cycle end-of-frame acknowledge
    always_ff @(posedge system_clk_in) begin
        if (rst_in) frame_complete_out <= 1'b0;
        else        frame_complete_out <= frame_done_in;
    end

`ifdef PIXEL_COUNT_EN
    logic [ADDR_W-1:0] we_cnt;
    logic [ADDR_W-1:0] cnt_next;

    // Running write count including any pulse in the current cycle, saturating
    always_comb begin
        cnt_next = we_cnt;
        if (bram_we_out && (we_cnt != CNT_SAT)) cnt_next = we_cnt + 1'b1;
    end

    // Latch the frame total on frame_done_in and restart the count
    always_ff @(posedge system_clk_in) begin
        if (rst_in) begin
            we_cnt                <= '0;
            frame_pixel_count_out <= '0;
        end else if (frame_done_in) begin
            we_cnt                <= '0;
            frame_pixel_count_out <= cnt_next;
        end else begin
            we_cnt <= cnt_next;
        end
    end
`endif

endmodule

// File: tb/tb_downsample_writer.sv
// Self-checking bench for downsample_writer with a behavioural 2x2 average model.
module tb_downsample_writer;

    // Frame geometry for this bench
    localparam int H  = 32;
    localparam int V  = 24;
    localparam int HO = H / 2;
    localparam int VO = V / 2;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        data_valid_in = 1'b0;
    logic [6:0]  pixel_in = '0;
    logic [10:0] hcount_in = '0;
    logic [9:0]  vcount_in = '0;
    logic        frame_done_in = 1'b0;
    logic        bram_we_out;
    logic [14:0] bram_addr_out;
    logic [6:0]  bram_data_out;
    logic        frame_complete_out;
`ifdef PIXEL_COUNT_EN
    logic [14:0] frame_pixel_count_out;
`endif

    always #5 clk = ~clk;

    downsample_writer #(.H_IN(H), .V_IN(V)) dut (
        .system_clk_in      (clk),
        .rst_in             (rst_in),
        .data_valid_in      (data_valid_in),
        .pixel_in           (pixel_in),
        .hcount_in          (hcount_in),
        .vcount_in          (vcount_in),
        .frame_done_in      (frame_done_in),
        .bram_we_out        (bram_we_out),
        .bram_addr_out      (bram_addr_out),
        .bram_data_out      (bram_data_out),
        .frame_complete_out (frame_complete_out)
`ifdef PIXEL_COUNT_EN
        ,
        .frame_pixel_count_out (frame_pixel_count_out)
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: pair sums of the last even row per output column,
    // the unconsumed even pixel (-1 = none), and write bookkeeping
    int top_pair [HO];
    int pend = -1;
    int wr_cnt = 0;
    int last_cnt = 0;
    int frame_writes = 0;
    int last_addr = 0;
    int last_data = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        pend = -1; wr_cnt = 0; last_addr = 0; last_data = 0;
        chk("rst_we", bram_we_out, 0);
        chk("rst_addr", bram_addr_out, 0);
        chk("rst_data", bram_data_out, 0);
        chk("rst_complete", frame_complete_out, 0);
`ifdef PIXEL_COUNT_EN
        chk("rst_count", frame_pixel_count_out, 0);
`endif
    endtask

    // Drive one strobe, predict its effect from the averaging rules, check the
    // following cycle and an idle cycle after it
    task automatic send(input int p, input int h, input int v, input bit fd);
        bit ew;
        int ea, ed, s;
        ew = 0; ea = last_addr; ed = last_data;
        data_valid_in = 1'b1; pixel_in = 7'(p); hcount_in = 11'(h);
        vcount_in = 10'(v); frame_done_in = fd;
        if (fd) begin
            pend = -1;
            last_cnt = (wr_cnt > 32767) ? 32767 : wr_cnt;
            wr_cnt = 0;
        end else if (h < H && v < V) begin
            if (h % 2 == 0) pend = p;
            else if (pend >= 0) begin
                s = pend + p;
                pend = -1;
                if (v % 2 == 0) top_pair[h/2] = s;
                else begin
                    ew = 1;
                    ea = (v / 2) * HO + h / 2;
                    ed = (top_pair[h/2] + s) / 4;
                end
            end
        end
        tick();
        data_valid_in = 1'b0; frame_done_in = 1'b0;
        chk("we", bram_we_out, ew);
        chk("addr", bram_addr_out, ea);
        chk("data", bram_data_out, ed);
        chk("complete", frame_complete_out, fd);
`ifdef PIXEL_COUNT_EN
        if (fd) chk("pixel_count", frame_pixel_count_out, last_cnt);
`endif
        if (ew) begin
            wr_cnt++; frame_writes++; last_addr = ea; last_data = ed;
        end
        tick();
        chk("we_idle", bram_we_out, 0);
        chk("complete_idle", frame_complete_out, 0);
        repeat ($urandom_range(0, 1)) tick();
    endtask

    // Raster rows v0..v1; mode 0 constant, 1 random, 2 random with stray
    // out-of-frame strobes mixed in
    task automatic send_rows(input int v0, input int v1, input int mode, input int cval);
        for (int v = v0; v <= v1; v++) begin
            for (int h = 0; h < H; h++) begin
                if (mode == 2 && $urandom_range(0, 15) == 0) begin
                    if ($urandom_range(0, 1) == 1) send($urandom_range(0, 127), H + $urandom_range(0, 7), v, 0);
                    else                           send($urandom_range(0, 127), h, V + $urandom_range(0, 7), 0);
                end
                send((mode == 0) ? cval : $urandom_range(0, 127), h, v, 0);
            end
        end
    endtask

    initial begin
        repeat (2) tick();
        do_reset();

        // Single 2x2 block at the origin
        send(10, 0, 0, 0); send(20, 1, 0, 0);
        send(30, 0, 1, 0); send(40, 1, 1, 0);
        chk("t1_data", bram_data_out, 25);
        chk("t1_addr", bram_addr_out, 0);
        send(0, 0, 0, 1);

        // Full constant frame
        frame_writes = 0;
        send_rows(0, V - 1, 0, 127);
        chk("full_writes", frame_writes, HO * VO);
        chk("full_last_addr", bram_addr_out, HO * VO - 1);
        chk("full_last_data", bram_data_out, 127);
        send(0, 0, 0, 1);

        // Odd column with no even partner is dropped
        send(10, 0, 0, 0); send(20, 1, 0, 0);
        send(99, 1, 1, 0);
        send(30, 0, 1, 0); send(40, 1, 1, 0);
        chk("orphan_data", bram_data_out, 25);
        send(0, 0, 0, 1);

        // frame_done coincident with the last odd-row odd-column sample
        send_rows(0, 0, 1, 0);
        for (int h = 0; h < H - 1; h++) send($urandom_range(0, 127), h, 1, 0);
        send(55, H - 1, 1, 1);
        send(1, 0, 0, 0); send(2, 1, 0, 0);
        send(3, 0, 1, 0); send(4, 1, 1, 0);
        chk("after_fd_addr", bram_addr_out, 0);
        send(0, 0, 0, 1);

        // Random frame with stray strobes
        frame_writes = 0;
        send_rows(0, V - 1, 2, 0);
        chk("rand_writes", frame_writes, HO * VO);
        send(0, 0, 0, 1);

        // Half frame
        frame_writes = 0;
        send_rows(0, V / 2 - 1, 1, 0);
        chk("half_writes", frame_writes, HO * VO / 2);
        send(0, 0, 0, 1);

        // Reset in the middle of an odd row, then a fresh frame
        send_rows(0, 12, 1, 0);
        for (int h = 0; h < H / 2; h++) send($urandom_range(0, 127), h, 13, 0);
        do_reset();
        send(8, 0, 0, 0); send(8, 1, 0, 0);
        send(8, 0, 1, 0); send(8, 1, 1, 0);
        chk("post_rst_addr", bram_addr_out, 0);
        chk("post_rst_data", bram_data_out, 8);
        send(0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
